// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM March C- BIST controller: operation
// codes, the six-element March C- table and the controller state encoding.
// No ports; imported by sram_bist_addr_gen and sram_bist_march_ctrl.
package sram_bist_pkg;

  // W0 = write D0, R0W1 = read D0 then write D1, R1W0 = read D1 then write D0,
  // R0 = read D0. D0 is all zeros, D1 is all ones.
  typedef enum logic [1:0] {
    W0   = 2'd0,
    R0W1 = 2'd1,
    R1W0 = 2'd2,
    R0   = 2'd3
  } march_op_e;

  typedef struct packed {
    march_op_e op;
    logic      down;  // 1: addresses run NumWords-1 down to 0
  } march_elem_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam int unsigned NumElems = 6;
  localparam logic [2:0]  LastElem = 3'd5;

  // March C- table, entry 0 in the least significant slot.
  localparam march_elem_t [NumElems-1:0] MarchTable = {
    {R0,   1'b0},   // e5
    {R1W0, 1'b1},   // e4
    {R0W1, 1'b1},   // e3
    {R1W0, 1'b0},   // e2
    {R0W1, 1'b0},   // e1
    {W0,   1'b0}    // e0
  };

  // Two accesses per address for the read-then-write elements.
  function automatic logic op_is_pair(input march_op_e op);
    return (op == R0W1) || (op == R1W0);
  endfunction

  // Background expected on the read access of an element.
  function automatic logic op_read_one(input march_op_e op);
    return (op == R1W0);
  endfunction

  // Background written by the write access of an element.
  function automatic logic op_write_one(input march_op_e op);
    return (op == R0W1);
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down word address counter for the March engine; reloads the element start address.
// Latency: addr_o is registered, last_o is combinational from the current address.
// Backpressure: none; advances only when step_i or load_i is asserted.
//
// Ports: clk_i/rst_ni clock and async active-low reset; load_i with load_down_i
// reloads 0 (up) or NumWords-1 (down); step_i advances one word in direction
// down_i; addr_o current address; last_o high on the final address of the element.
module sram_bist_addr_gen
  import sram_bist_pkg::*;
#(
  parameter int unsigned NumWords  = 64,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 load_down_i,
  input  logic                 step_i,
  input  logic                 down_i,
  output logic [AddrWidth-1:0] addr_o,
  output logic                 last_o
);

  localparam logic [AddrWidth-1:0] MaxAddr = AddrWidth'(NumWords - 1);

  logic [AddrWidth-1:0] addr_q, addr_d;

  // Load wins over step: at an element boundary the controller reloads
  // instead of stepping, so the counter never leaves 0..NumWords-1 even
  // when NumWords is not a power of two.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? MaxAddr : '0;
    end else if (step_i) begin
      addr_d = down_i ? (addr_q - 1'b1) : (addr_q + 1'b1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = down_i ? (addr_q == '0) : (addr_q == MaxAddr);

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// March C- BIST initiator for one SRAM macro BIST port, with pass/fail and first-fail capture.
// Latency: 10*NumWords+2 edges from the start edge to done_o; read data compared one cycle after ren.
// Backpressure: none; one memory operation per cycle, start_i ignored while busy.
//
// Ports: clk_i/rst_ni clock and async active-low reset (reset aborts a test);
// start_i start pulse (IDLE/DONE only); busy_o, done_o, pass_o, fail_addr_o,
// fail_elem_o status/result; bist_* drive the macro A_BIST_* pins;
// bist_dout_i is the macro A_DOUT.
module sram_bist_march_ctrl
  import sram_bist_pkg::*;
#(
  parameter int unsigned NumWords  = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [AddrWidth-1:0] fail_addr_o,
  output logic [2:0]           fail_elem_o,
  output logic                 bist_en_o,
  output logic                 bist_men_o,
  output logic                 bist_wen_o,
  output logic                 bist_ren_o,
  output logic [AddrWidth-1:0] bist_addr_o,
  output logic [DataWidth-1:0] bist_din_o,
  output logic [DataWidth-1:0] bist_bm_o,
  input  logic [DataWidth-1:0] bist_dout_i
);

  bist_state_e          state_q, state_d;
  logic [2:0]           elem_q, elem_d;
  logic                 phase_q, phase_d;     // 0: first access at this address
  logic                 rd_vld_q, rd_vld_d;   // a read was issued last cycle
  logic                 rd_one_q, rd_one_d;   // its expected background
  logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]           rd_elem_q, rd_elem_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [AddrWidth-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]           fail_elem_q, fail_elem_d;

  march_op_e            cur_op;
  logic                 cur_down;
  logic [2:0]           nxt_idx;
  logic                 run, pair, is_read, is_write;
  logic                 addr_done, elem_end, last_op, start_ok, mismatch;
  logic [AddrWidth-1:0] ag_addr;
  logic                 ag_last, ag_load, ag_load_down, ag_step;

  always_comb begin
    cur_op    = MarchTable[elem_q].op;
    cur_down  = MarchTable[elem_q].down;
    // Clamped so the table lookup stays in range on the final element.
    nxt_idx   = (elem_q == LastElem) ? elem_q : (elem_q + 3'd1);
    run       = (state_q == ST_RUN);
    pair      = op_is_pair(cur_op);
    is_read   = (cur_op != W0) && !phase_q;
    is_write  = !is_read;
    addr_done = !pair || phase_q;
    elem_end  = addr_done && ag_last;
    last_op   = elem_end && (elem_q == LastElem);
    start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    mismatch  = rd_vld_q && (bist_dout_i != {DataWidth{rd_one_q}});
  end

  assign ag_load      = start_ok || (run && elem_end && !last_op);
  assign ag_load_down = start_ok ? MarchTable[0].down : MarchTable[nxt_idx].down;
  assign ag_step      = run && addr_done && !elem_end;

  sram_bist_addr_gen #(
    .NumWords  (NumWords),
    .AddrWidth (AddrWidth)
  ) u_addr_gen (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (ag_load),
    .load_down_i (ag_load_down),
    .step_i      (ag_step),
    .down_i      (cur_down),
    .addr_o      (ag_addr),
    .last_o      (ag_last)
  );

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    // The compare stage only arms when the FSM stays in RUN or goes to
    // DRAIN, so a stale read can never be compared after a restart.
    rd_vld_d    = run && is_read && !mismatch;
    rd_one_d    = op_read_one(cur_op);
    rd_addr_d   = ag_addr;
    rd_elem_d   = elem_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          elem_d      = '0;
          phase_d     = 1'b0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      ST_RUN: begin
        if (mismatch) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = rd_addr_q;
          fail_elem_d = rd_elem_q;
        end else if (last_op) begin
          state_d = ST_DRAIN;
        end else begin
          phase_d = pair && !phase_q;
          if (elem_end) begin
            elem_d = nxt_idx;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        if (mismatch) begin
          pass_d      = 1'b0;
          fail_addr_d = rd_addr_q;
          fail_elem_d = rd_elem_q;
        end else begin
          pass_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      phase_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_one_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      rd_vld_q    <= rd_vld_d;
      rd_one_q    <= rd_one_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  // Macro pins decode straight from registered state, so the async reset
  // hands the macro back to its functional port without waiting for a clock.
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bist_en_o   = busy_o;
  assign bist_men_o  = run;
  assign bist_wen_o  = run && is_write;
  assign bist_ren_o  = run && is_read;
  assign bist_addr_o = run ? ag_addr : '0;
  assign bist_din_o  = (run && is_write) ? {DataWidth{op_write_one(cur_op)}} : '0;
  assign bist_bm_o   = run ? {DataWidth{1'b1}} : '0;

  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;

endmodule
